// File: rtl/universal_shift_reg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg
//
// Purpose:
//   Parametrised universal shift register for the divider datapath and other
//   arithmetic blocks. It supports parallel load, logical, arithmetic, rotate
//   and serial-fill shifts.
//
//   A multi-position shift runs one bit per clock. A start/busy/done
//   handshake lets a controller request an N-position shift and then wait
//   for it to finish. The register also keeps the bit that was most
//   recently shifted out.
//
// Parameters:
//   WIDTH      register width in bits (>= 2)
//   CW         width of the shift-amount input
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   i_ld       parallel load of i_d (only honoured when idle)
//   i_d        parallel load data
//   i_start    request a multi-position shift (only honoured when idle)
//   i_mode     shift mode, latched at start
//   i_amt      number of one-bit steps, latched at start
//   i_left_in  serial fill bit for mode SRI, sampled on each step edge
//   i_right_in serial fill bit for mode SLI, sampled on each step edge
//   o_q        register contents
//   o_shout    bit most recently shifted out
//   o_busy     high while a shift sequence is in progress
//   o_done     one-cycle completion pulse
// ---------------------------------------------------------------------------
module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_ld,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_start,
   input  logic [2:0]       i_mode,
   input  logic [CW-1:0]    i_amt,
   input  logic             i_left_in,
   input  logic             i_right_in,
   output logic [WIDTH-1:0] o_q,
   output logic             o_shout,
   output logic             o_busy,
   output logic             o_done
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_nextQ;
   logic             r_shout;
   logic             w_nextShout;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_nextCnt;
   logic [2:0]       r_mode;
   logic [2:0]       w_nextMode;
   logic             r_done;
   logic             w_nextDone;
   logic [WIDTH-1:0] w_stepQ;
   logic             w_stepShout;

   // This block computes the result of a single one-bit step in the latched
   // mode. The reserved mode falls through to the default, so q and shout
   // hold while the counter keeps running. That keeps busy/done timing the
   // same as for a real shift.
   always_comb begin
      w_stepQ     = r_q;
      w_stepShout = r_shout;
      case (r_mode)
         3'b000: begin
            w_stepQ     = {r_q[WIDTH-2:0], 1'b0};
            w_stepShout = r_q[WIDTH-1];
         end
         3'b001: begin
            w_stepQ     = {1'b0, r_q[WIDTH-1:1]};
            w_stepShout = r_q[0];
         end
         3'b010: begin
            w_stepQ     = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            w_stepShout = r_q[0];
         end
         3'b011: begin
            w_stepQ     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            w_stepShout = r_q[WIDTH-1];
         end
         3'b100: begin
            w_stepQ     = {r_q[0], r_q[WIDTH-1:1]};
            w_stepShout = r_q[0];
         end
         3'b101: begin
            w_stepQ     = {r_q[WIDTH-2:0], i_right_in};
            w_stepShout = r_q[WIDTH-1];
         end
         3'b110: begin
            w_stepQ     = {i_left_in, r_q[WIDTH-1:1]};
            w_stepShout = r_q[0];
         end
         default: begin
            w_stepQ     = r_q;
            w_stepShout = r_shout;
         end
      endcase
   end

   // This block holds the next-state and datapath decisions.
   // In IDLE, a load takes priority over start, so a start that arrives
   // together with a load is dropped. A zero-length start goes straight to
   // the done pulse without entering SHIFT.
   // In SHIFT, the block counts down and leaves on the edge where the
   // counter was 1. During SHIFT, ld, start, mode and amt are all ignored.
   always_comb begin
      w_nextState = r_state;
      w_nextQ     = r_q;
      w_nextShout = r_shout;
      w_nextCnt   = r_cnt;
      w_nextMode  = r_mode;
      w_nextDone  = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_ld) begin
               w_nextQ     = i_d;
               w_nextShout = 1'b0;
            end else if (i_start) begin
               if (i_amt == '0) begin
                  w_nextDone = 1'b1;
               end else begin
                  w_nextMode  = i_mode;
                  w_nextCnt   = i_amt;
                  w_nextState = SHIFT;
               end
            end
         end
         SHIFT: begin
            w_nextQ     = w_stepQ;
            w_nextShout = w_stepShout;
            w_nextCnt   = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               w_nextState = IDLE;
               w_nextDone  = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // This is the state register. Reset abandons any shift that is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // These are the datapath and handshake registers. They share the same
   // synchronous reset as the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q     <= '0;
         r_shout <= 1'b0;
         r_cnt   <= '0;
         r_mode  <= 3'b000;
         r_done  <= 1'b0;
      end else begin
         r_q     <= w_nextQ;
         r_shout <= w_nextShout;
         r_cnt   <= w_nextCnt;
         r_mode  <= w_nextMode;
         r_done  <= w_nextDone;
      end
   end

   assign o_q     = r_q;
   assign o_shout = r_shout;
   assign o_busy  = (r_state == SHIFT);
   assign o_done  = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_reg
//
// Purpose:
//   Self-checking bench for universal_shift_reg with WIDTH=8.
//   A reference model tracks the register value and the shifted-out bit
//   using plain arithmetic on each step. Directed scenarios are followed by
//   randomized shift sequences.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_universal_shift_reg;

   localparam int W  = 8;
   localparam int CW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_ld;
   logic [W-1:0]  i_d;
   logic          i_start;
   logic [2:0]    i_mode;
   logic [CW-1:0] i_amt;
   logic          i_left_in;
   logic          i_right_in;
   logic [W-1:0]  o_q;
   logic          o_shout;
   logic          o_busy;
   logic          o_done;

   int            testCount = 0;
   int            failCount = 0;
   logic [W-1:0]  mQ = '0;
   logic          mShout = 1'b0;

   universal_shift_reg #(.WIDTH(W), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_ld       (i_ld),
      .i_d        (i_d),
      .i_start    (i_start),
      .i_mode     (i_mode),
      .i_amt      (i_amt),
      .i_left_in  (i_left_in),
      .i_right_in (i_right_in),
      .o_q        (o_q),
      .o_shout    (o_shout),
      .o_busy     (o_busy),
      .o_done     (o_done)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   // Advance one rising edge, then settle away from the edge before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ld, input logic [W-1:0] d,
                                input logic start, input logic [2:0] mode,
                                input logic [CW-1:0] amt,
                                input logic li, input logic ri);
      i_ld       = ld;
      i_d        = d;
      i_start    = start;
      i_mode     = mode;
      i_amt      = amt;
      i_left_in  = li;
      i_right_in = ri;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      testCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference step, written as arithmetic on the value rather than as bit
   // concatenations.
   task automatic modelStep(input logic [2:0] mode, input logic [W-1:0] q,
                            input logic li, input logic ri,
                            output logic [W-1:0] nq, output logic nsh);
      logic [W-1:0] liW;
      logic [W-1:0] riW;
      liW = W'(li);
      riW = W'(ri);
      nq  = q;
      nsh = mShout;
      case (mode)
         3'd0: begin nq = q << 1;                          nsh = q[W-1]; end
         3'd1: begin nq = q >> 1;                          nsh = q[0];   end
         3'd2: begin nq = W'($signed(q) >>> 1);            nsh = q[0];   end
         3'd3: begin nq = (q << 1) | (q >> (W-1));         nsh = q[W-1]; end
         3'd4: begin nq = (q >> 1) | (q << (W-1));         nsh = q[0];   end
         3'd5: begin nq = (q << 1) | riW;                  nsh = q[W-1]; end
         3'd6: begin nq = (q >> 1) | (liW << (W-1));       nsh = q[0];   end
         default: begin nq = q;                            nsh = mShout; end
      endcase
   endtask

   task automatic doLoad(input logic [W-1:0] v);
      applyStimulus(1'b1, v, 1'b0, 3'd0, '0, 1'b0, 1'b0);
      tick();
      mQ     = v;
      mShout = 1'b0;
      checkOutput("load_q", 32'(o_q), 32'(mQ));
      checkOutput("load_shout", 32'(o_shout), 32'(mShout));
      checkOutput("load_busy", 32'(o_busy), 32'd0);
      applyStimulus(1'b0, '0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
   endtask

   // Issue a shift and follow it to completion. The task returns in the
   // done cycle. The caller's next request therefore exercises back-to-back
   // acceptance. When ldBusy is set, a load of 8'h55 is held while the
   // block is busy.
   task automatic doShift(input logic [2:0] mode, input logic [CW-1:0] amt,
                          input logic [15:0] rBits, input logic [15:0] lBits,
                          input logic ldBusy, input string tag);
      logic [W-1:0] nq;
      logic         ns;
      applyStimulus(1'b0, W'($urandom), 1'b1, mode, amt, 1'b0, 1'b0);
      tick();
      applyStimulus(ldBusy && (amt > 1), 8'h55, 1'b0, 3'($urandom),
                    CW'($urandom), 1'b0, 1'b0);
      if (amt == 0) begin
         checkOutput({tag, "_z_busy"}, 32'(o_busy), 32'd0);
         checkOutput({tag, "_z_done"}, 32'(o_done), 32'd1);
         checkOutput({tag, "_z_q"}, 32'(o_q), 32'(mQ));
      end else begin
         for (int k = 0; k < int'(amt); k++) begin
            checkOutput({tag, "_busy"}, 32'(o_busy), 32'd1);
            checkOutput({tag, "_done_early"}, 32'(o_done), 32'd0);
            i_ld       = ldBusy && (k < int'(amt) - 1);
            i_right_in = rBits[k];
            i_left_in  = lBits[k];
            tick();
            modelStep(mode, mQ, lBits[k], rBits[k], nq, ns);
            mQ     = nq;
            mShout = ns;
         end
         checkOutput({tag, "_busy_end"}, 32'(o_busy), 32'd0);
         checkOutput({tag, "_done"}, 32'(o_done), 32'd1);
         checkOutput({tag, "_q"}, 32'(o_q), 32'(mQ));
         checkOutput({tag, "_shout"}, 32'(o_shout), 32'(mShout));
      end
      applyStimulus(1'b0, '0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
   endtask

   // All directed and random steps, run in one linear sequence.
   initial begin
      applyStimulus(1'b0, '0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      checkOutput("rst_q", 32'(o_q), 32'h00);
      checkOutput("rst_shout", 32'(o_shout), 32'd0);
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_done", 32'(o_done), 32'd0);
      rst = 1'b0;
      tick();

      // Reset in the middle of a shift abandons it.
      doLoad(8'hFF);
      applyStimulus(1'b0, '0, 1'b1, 3'b001, CW'(5), 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
      tick();
      checkOutput("mid_busy_pre", 32'(o_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_q", 32'(o_q), 32'h00);
      checkOutput("mid_shout", 32'(o_shout), 32'd0);
      checkOutput("mid_busy", 32'(o_busy), 32'd0);
      checkOutput("mid_done", 32'(o_done), 32'd0);
      mQ     = '0;
      mShout = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("mid_no_done", 32'(o_done), 32'd0);
         checkOutput("mid_no_busy", 32'(o_busy), 32'd0);
      end

      // Arithmetic shift right keeps the sign bit.
      doLoad(8'hB4);
      doShift(3'b010, CW'(3), 16'h0, 16'h0, 1'b0, "asr");
      checkOutput("asr_q_const", 32'(o_q), 32'hF6);
      checkOutput("asr_shout_const", 32'(o_shout), 32'd1);
      tick();
      checkOutput("asr_done_pulse", 32'(o_done), 32'd0);

      // Rotates wrap modulo the width.
      doLoad(8'h81);
      doShift(3'b011, CW'(9), 16'h0, 16'h0, 1'b0, "rol9");
      checkOutput("rol9_q_const", 32'(o_q), 32'h03);
      checkOutput("rol9_shout_const", 32'(o_shout), 32'd1);
      tick();
      doLoad(8'h81);
      doShift(3'b100, CW'(8), 16'h0, 16'h0, 1'b0, "ror8");
      checkOutput("ror8_q_const", 32'(o_q), 32'h81);
      tick();

      // Serial fill from the right, bit order 1,0,1,1.
      doLoad(8'h00);
      doShift(3'b101, CW'(4), 16'b1101, 16'h0, 1'b0, "sli");
      checkOutput("sli_q_const", 32'(o_q), 32'h0B);
      checkOutput("sli_shout_const", 32'(o_shout), 32'd0);
      tick();

      // A zero-length start pulses done without ever becoming busy.
      doShift(3'b000, CW'(0), 16'h0, 16'h0, 1'b0, "amt0");
      checkOutput("amt0_q_const", 32'(o_q), 32'h0B);
      tick();
      checkOutput("amt0_done_off", 32'(o_done), 32'd0);

      // When load and start arrive together, the load wins.
      applyStimulus(1'b1, 8'h3C, 1'b1, 3'b000, CW'(3), 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
      mQ     = 8'h3C;
      mShout = 1'b0;
      checkOutput("ldst_q", 32'(o_q), 32'h3C);
      checkOutput("ldst_busy", 32'(o_busy), 32'd0);
      tick();
      checkOutput("ldst_busy2", 32'(o_busy), 32'd0);
      checkOutput("ldst_done", 32'(o_done), 32'd0);

      // A load held while busy is ignored.
      doShift(3'b001, CW'(3), 16'h0, 16'h0, 1'b1, "ldbusy");
      checkOutput("ldbusy_q_const", 32'(o_q), 32'h07);
      tick();

      // The reserved mode holds q but keeps the handshake timing.
      doShift(3'b111, CW'(2), 16'h0, 16'h0, 1'b0, "rsv");
      checkOutput("rsv_q_const", 32'(o_q), 32'h07);
      tick();

      // A back-to-back start is accepted in the done cycle.
      doLoad(8'h01);
      doShift(3'b000, CW'(1), 16'h0, 16'h0, 1'b0, "b2b1");
      doShift(3'b000, CW'(2), 16'h0, 16'h0, 1'b0, "b2b2");
      checkOutput("b2b_q_const", 32'(o_q), 32'h08);
      tick();

      // Randomized sequences checked against the model.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            doLoad(W'($urandom));
         end
         doShift(3'($urandom_range(0, 7)), CW'($urandom_range(0, 15)),
                 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 "rnd");
         tick();
         checkOutput("rnd_done_off", 32'(o_done), 32'd0);
         checkOutput("rnd_idle", 32'(o_busy), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
